// File: rtl/toy_cpu_sequencer_if.sv
// Port group between the program loader/controller and the instruction sequencer.
// The master side loads bytes and controls execution; the slave side issues instructions.
interface toy_cpu_sequencer_if #(
    parameter int AW = 3
);
    logic          load_valid;
    logic [7:0]    load_data;
    logic          clear;
    logic          run;
    logic          loop;
    logic          op_valid;
    logic [2:0]    opcode;
    logic [2:0]    src_a;
    logic [2:0]    src_b;
    logic [2:0]    dest;
    logic [7:0]    imm;
    logic          busy;
    logic          full;
    logic [AW:0]   count;

    modport master (
        output load_valid, load_data, clear, run, loop,
        input  op_valid, opcode, src_a, src_b, dest, imm, busy, full, count
    );

    modport slave (
        input  load_valid, load_data, clear, run, loop,
        output op_valid, opcode, src_a, src_b, dest, imm, busy, full, count
    );
endinterface

// File: rtl/toy_cpu_sequencer.sv
// Packs 3-byte program entries into a small store and replays them to toy_cpu,
// one instruction per cycle, with optional looping at program end.
module toy_cpu_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    toy_cpu_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    // Entry layout: {opcode, src_a, src_b, dest, imm}
    logic [19:0]   mem [DEPTH];

    logic [1:0]    state;
    logic [AW-1:0] pc;
    logic [AW:0]   count;
    logic [1:0]    phase;
    logic [5:0]    byte0_hold;
    logic [5:0]    byte1_hold;

    logic          op_valid_r;
    logic [2:0]    opcode_r, src_a_r, src_b_r, dest_r;
    logic [7:0]    imm_r;

    logic          full;
    logic          issue_en;
    logic [AW-1:0] issue_idx;
    logic          issue_last;
    logic          load_en;
    logic          mem_we;
    logic          unused_low_bits;

    assign full            = (count == (AW+1)'(DEPTH));
    assign unused_low_bits = ^bus.load_data[1:0];

    // run outranks clear and load in IDLE; loading is only possible when idle and not running
    assign issue_en   = ((state == S_IDLE) && bus.run && (count != '0)) ||
                        ((state == S_RUN) && bus.run);
    assign issue_idx  = (state == S_IDLE) ? '0 : pc;
    assign issue_last = ({1'b0, issue_idx} == (count - 1'b1));
    assign load_en    = (state == S_IDLE) && !bus.run && !bus.clear && bus.load_valid && !full;
    assign mem_we     = load_en && (phase == 2'd2);

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[count[AW-1:0]] <= {byte0_hold, byte1_hold, bus.load_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            count      <= '0;
            phase      <= 2'd0;
            byte0_hold <= '0;
            byte1_hold <= '0;
            op_valid_r <= 1'b0;
            opcode_r   <= '0;
            src_a_r    <= '0;
            src_b_r    <= '0;
            dest_r     <= '0;
            imm_r      <= '0;
        end else begin
            op_valid_r <= 1'b0;

            if (issue_en) begin
                {opcode_r, src_a_r, src_b_r, dest_r, imm_r} <= mem[issue_idx];
                op_valid_r <= 1'b1;
                if (issue_last) begin
                    if (bus.loop) begin
                        pc    <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_HALT;
                    end
                end else begin
                    pc    <= issue_idx + 1'b1;
                    state <= S_RUN;
                end
            end

            case (state)
                S_IDLE: begin
                    if (bus.run) begin
                        phase <= 2'd0;
                    end else if (bus.clear) begin
                        count <= '0;
                        phase <= 2'd0;
                    end else if (load_en) begin
                        case (phase)
                            2'd0: begin
                                byte0_hold <= bus.load_data[7:2];
                                phase      <= 2'd1;
                            end
                            2'd1: begin
                                byte1_hold <= bus.load_data[7:2];
                                phase      <= 2'd2;
                            end
                            default: begin
                                count <= count + 1'b1;
                                phase <= 2'd0;
                            end
                        endcase
                    end
                end
                S_HALT: begin
                    if (!bus.run) begin
                        state <= S_IDLE;
                        pc    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.op_valid = op_valid_r;
    assign bus.opcode   = opcode_r;
    assign bus.src_a    = src_a_r;
    assign bus.src_b    = src_b_r;
    assign bus.dest     = dest_r;
    assign bus.imm      = imm_r;
    assign bus.busy     = (state != S_IDLE);
    assign bus.full     = full;
    assign bus.count    = count;
endmodule

// File: tb/tb_toy_cpu_sequencer.sv
// Directed bench for toy_cpu_sequencer: loading, run/pause/loop/halt, full/clear,
// partial-entry discard and asynchronous reset.
module tb_toy_cpu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    toy_cpu_sequencer_if #(.AW(3)) bus ();

    toy_cpu_sequencer #(.DEPTH(8), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.load_valid = 1'b1;
        bus.load_data  = b;
        step();
        bus.load_valid = 1'b0;
    endtask

    task automatic load_instr(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                              input logic [2:0] d, input logic [7:0] im);
        send_byte({op, a, 2'b00});
        send_byte({b, d, 2'b00});
        send_byte(im);
    endtask

    task automatic chk_issue(input string tag, input logic [2:0] op, input logic [2:0] a,
                             input logic [2:0] b, input logic [2:0] d, input logic [7:0] im);
        chk({tag, ".vld"}, 32'(bus.op_valid), 1);
        chk({tag, ".fields"}, 32'({bus.opcode, bus.src_a, bus.src_b, bus.dest, bus.imm}),
            32'({op, a, b, d, im}));
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.clear      = 1'b0;
        bus.run        = 1'b0;
        bus.loop       = 1'b0;
        #1;
        chk("rst.op_valid", 32'(bus.op_valid), 0);
        chk("rst.fields", 32'({bus.opcode, bus.src_a, bus.src_b, bus.dest, bus.imm}), 0);
        chk("rst.busy", 32'(bus.busy), 0);
        chk("rst.full", 32'(bus.full), 0);
        chk("rst.count", 32'(bus.count), 0);
        #13 rst = 1'b0;
        step();

        // Three-instruction program, single pass
        load_instr(3'd7, 3'd0, 3'd0, 3'd1, 8'h05);
        load_instr(3'd7, 3'd0, 3'd0, 3'd2, 8'h03);
        load_instr(3'd1, 3'd1, 3'd2, 3'd3, 8'h00);
        chk("load3.count", 32'(bus.count), 3);
        chk("load3.busy", 32'(bus.busy), 0);
        bus.run = 1'b1;
        step(); chk_issue("p1.e0", 3'd7, 3'd0, 3'd0, 3'd1, 8'h05);
        chk("p1.busy", 32'(bus.busy), 1);
        step(); chk_issue("p1.e1", 3'd7, 3'd0, 3'd0, 3'd2, 8'h03);
        step(); chk_issue("p1.e2", 3'd1, 3'd1, 3'd2, 3'd3, 8'h00);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("p1.halt.vld", 32'(bus.op_valid), 0);
            chk("p1.halt.busy", 32'(bus.busy), 1);
            chk("p1.halt.dest", 32'(bus.dest), 3);
            chk("p1.halt.count", 32'(bus.count), 3);
        end
        bus.run = 1'b0;
        step();
        chk("p1.idle.busy", 32'(bus.busy), 0);

        // Looping run, then drop loop
        bus.loop = 1'b1;
        bus.run  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("loop.vld", 32'(bus.op_valid), 1);
            chk("loop.dest", 32'(bus.dest), 32'((i % 3) + 1));
        end
        bus.loop = 1'b0;
        step(); chk_issue("loop.last", 3'd1, 3'd1, 3'd2, 3'd3, 8'h00);
        step(); chk("loop.halt.vld", 32'(bus.op_valid), 0);
        chk("loop.halt.busy", 32'(bus.busy), 1);
        bus.run = 1'b0;
        step();
        chk("loop.idle.busy", 32'(bus.busy), 0);

        // Pause after entry 1, then resume
        bus.run = 1'b1;
        step(); chk("pause.e0.dest", 32'(bus.dest), 1);
        step(); chk("pause.e1.dest", 32'(bus.dest), 2);
        bus.run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pause.vld", 32'(bus.op_valid), 0);
            chk("pause.hold.imm", 32'(bus.imm), 32'h03);
            chk("pause.busy", 32'(bus.busy), 1);
        end
        bus.run = 1'b1;
        step(); chk_issue("resume.e2", 3'd1, 3'd1, 3'd2, 3'd3, 8'h00);
        step(); chk("resume.halt.vld", 32'(bus.op_valid), 0);
        bus.run = 1'b0;
        step();

        // Fill to DEPTH, overflow bytes, replay, clear
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("clr1.count", 32'(bus.count), 0);
        for (int i = 0; i < 8; i++)
            load_instr(3'(i), 3'(7 - i), 3'(i + 1), 3'(i), 8'(8'h10 + i));
        chk("fill.full", 32'(bus.full), 1);
        chk("fill.count", 32'(bus.count), 8);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hEE);
        chk("over.count", 32'(bus.count), 8);
        chk("over.full", 32'(bus.full), 1);
        bus.run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_issue("full.e", 3'(i), 3'(7 - i), 3'(i + 1), 3'(i), 8'(8'h10 + i));
        end
        step(); chk("full.halt.vld", 32'(bus.op_valid), 0);
        bus.run = 1'b0;
        step();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("clr2.count", 32'(bus.count), 0);
        chk("clr2.full", 32'(bus.full), 0);
        bus.run = 1'b1;
        step();
        chk("empty.vld", 32'(bus.op_valid), 0);
        chk("empty.busy", 32'(bus.busy), 0);
        step();
        chk("empty.vld2", 32'(bus.op_valid), 0);
        bus.run = 1'b0;

        // Partial entry discarded by run
        load_instr(3'd3, 3'd2, 3'd1, 3'd4, 8'h44);
        send_byte(8'hA4);
        send_byte(8'hB8);
        chk("part.count", 32'(bus.count), 1);
        bus.run = 1'b1;
        step(); chk_issue("part.e0", 3'd3, 3'd2, 3'd1, 3'd4, 8'h44);
        step(); chk("part.halt.vld", 32'(bus.op_valid), 0);
        bus.run = 1'b0;
        step();
        load_instr(3'd5, 3'd1, 3'd3, 3'd6, 8'h66);
        chk("part.count2", 32'(bus.count), 2);
        bus.run = 1'b1;
        step(); chk_issue("part2.e0", 3'd3, 3'd2, 3'd1, 3'd4, 8'h44);
        step(); chk_issue("part2.e1", 3'd5, 3'd1, 3'd3, 3'd6, 8'h66);
        step(); chk("part2.halt.vld", 32'(bus.op_valid), 0);
        bus.run = 1'b0;
        step();

        // Asynchronous reset during a looping run
        bus.loop = 1'b1;
        bus.run  = 1'b1;
        step(); step(); step();
        chk_issue("arst.pre", 3'd3, 3'd2, 3'd1, 3'd4, 8'h44);
        #2 rst = 1'b1;
        #1;
        chk("arst.vld", 32'(bus.op_valid), 0);
        chk("arst.count", 32'(bus.count), 0);
        chk("arst.busy", 32'(bus.busy), 0);
        chk("arst.fields", 32'({bus.opcode, bus.src_a, bus.src_b, bus.dest, bus.imm}), 0);
        #3 rst = 1'b0;
        step();
        chk("post.vld", 32'(bus.op_valid), 0);
        chk("post.busy", 32'(bus.busy), 0);
        step();
        chk("post.vld2", 32'(bus.op_valid), 0);
        chk("post.count", 32'(bus.count), 0);
        bus.run  = 1'b0;
        bus.loop = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
